// File: rtl/pc_control_fsm.sv
// Multi-cycle fetch/decode/execute controller that drives the external PC's sel/jumpDir inputs
// and strobes the accumulator/ALU. Every instruction takes three clocks; HALT is absorbing.
module pc_control_fsm #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [N+3:0] instr_i,
  input  logic         zero_i,
  output logic [1:0]   sel,
  output logic [N-1:0] jumpDir,
  output logic [N+3:0] ir_o,
  output logic [1:0]   alu_op,
  output logic [N-1:0] imm,
  output logic         acc_we,
  output logic         halted,
  output logic         illegal,
  output logic [7:0]   retired
);

  typedef enum logic [1:0] {
    StFetch  = 2'b00,
    StDecode = 2'b01,
    StExec   = 2'b10,
    StHalt   = 2'b11
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpJmp  = 4'h4;
  localparam logic [3:0] OpJz   = 4'h5;
  localparam logic [3:0] OpJnz  = 4'h6;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelInc   = 2'b01;
  localparam logic [1:0] SelJump  = 2'b10;
  localparam logic [1:0] SelClear = 2'b11;

  state_e         state_q, state_d;
  logic [N+3:0]   ir_q, ir_d;
  logic           zf_q, zf_d;
  logic           halted_q, halted_d;
  logic           illegal_q, illegal_d;
  logic [7:0]     retired_q, retired_d;

  logic [3:0]     opcode;
  logic           op_halt;
  logic           op_illegal;

  assign opcode     = ir_q[N+3:N];
  assign op_halt    = (opcode == OpHalt);
  assign op_illegal = (opcode >= 4'h7) && (opcode <= 4'hE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      zf_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      zf_q      <= zf_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    zf_d      = zf_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    unique case (state_q)
      StFetch: begin
        if (run) begin
          ir_d    = instr_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Flag is frozen here so jumps see the result of the previous instruction.
        zf_d    = zero_i;
        state_d = StExec;
      end
      StExec: begin
        retired_d = retired_q + 8'd1;
        if (op_halt) begin
          halted_d = 1'b1;
          state_d  = StHalt;
        end else begin
          if (op_illegal) illegal_d = 1'b1;
          state_d = StFetch;
        end
      end
      StHalt: state_d = StHalt;
    endcase
  end

  always_comb begin
    sel    = SelHold;
    acc_we = 1'b0;
    alu_op = 2'b00;
    if (rst) begin
      sel = SelClear;
    end else if (state_q == StExec) begin
      case (opcode)
        OpNop: sel = SelInc;
        OpLdi: begin
          sel    = SelInc;
          acc_we = 1'b1;
          alu_op = 2'b00;
        end
        OpAdd: begin
          sel    = SelInc;
          acc_we = 1'b1;
          alu_op = 2'b01;
        end
        OpSub: begin
          sel    = SelInc;
          acc_we = 1'b1;
          alu_op = 2'b10;
        end
        OpJmp:  sel = SelJump;
        OpJz:   sel = zf_q ? SelJump : SelInc;
        OpJnz:  sel = zf_q ? SelInc : SelJump;
        OpHalt: sel = SelHold;
        default: sel = SelInc;
      endcase
    end
  end

  assign jumpDir = ir_q[N-1:0];
  assign imm     = ir_q[N-1:0];
  assign ir_o    = ir_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
